// File: rtl/flip_scheduler.sv
// flip_scheduler: sequences one WalkSAT flip step (break-value fetch, selection, flip)
// around the heuristic selector, keeping flip/random-walk statistics and a flip budget.
module flip_scheduler #(
    parameter int NSAT                          = 3,
    parameter int NSAT_BITS                     = 2,
    parameter int MAX_CLAUSES_PER_VARIABLE_BITS = 5,
    parameter int VAR_BITS                      = 10,
    parameter int SEL_LATENCY                   = 1,
    parameter int MAX_FLIPS                     = 1000
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start_i,
    input  logic [NSAT*VAR_BITS-1:0]                      clause_vars_i,
    output logic                                          busy_o,
    output logic                                          bv_req_o,
    output logic [VAR_BITS-1:0]                           bv_var_o,
    input  logic                                          bv_ack_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE_BITS-1:0]      bv_value_i,
    output logic [NSAT*MAX_CLAUSES_PER_VARIABLE_BITS-1:0] break_values_o,
    output logic                                          sel_valid_o,
    input  logic [NSAT_BITS-1:0]                          select_i,
    input  logic                                          random_sel_i,
    output logic                                          flip_req_o,
    output logic [VAR_BITS-1:0]                           flip_var_o,
    input  logic                                          flip_ack_i,
    output logic                                          done_o,
    output logic [31:0]                                   flip_count_o,
    output logic [31:0]                                   random_count_o,
    output logic                                          limit_o,
    output logic                                          sel_err_o
);
    localparam int BVB = MAX_CLAUSES_PER_VARIABLE_BITS;
    localparam int SCW = (SEL_LATENCY < 1) ? 1 : $clog2(SEL_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BV,
        S_SEL,
        S_FLIP,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [NSAT_BITS-1:0]   k_q;
    logic [SCW-1:0]         sel_cnt_q;
    logic [VAR_BITS-1:0]    vars_q [NSAT];
    logic                   bv_req_q;
    logic [VAR_BITS-1:0]    bv_var_q;
    logic [NSAT*BVB-1:0]    bv_vals_q;
    logic                   sel_valid_q;
    logic                   flip_req_q;
    logic [VAR_BITS-1:0]    flip_var_q;
    logic                   rnd_q;
    logic                   done_q;
    logic [31:0]            flip_count_q;
    logic [31:0]            random_count_q;
    logic                   sel_err_q;

    assign busy_o         = (state_q != S_IDLE);
    assign bv_req_o       = bv_req_q;
    assign bv_var_o       = bv_var_q;
    assign break_values_o = bv_vals_q;
    assign sel_valid_o    = sel_valid_q;
    assign flip_req_o     = flip_req_q;
    assign flip_var_o     = flip_var_q;
    assign done_o         = done_q;
    assign flip_count_o   = flip_count_q;
    assign random_count_o = random_count_q;
    assign sel_err_o      = sel_err_q;
    assign limit_o        = (flip_count_q == 32'(MAX_FLIPS));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            sel_cnt_q      <= '0;
            for (int unsigned i = 0; i < NSAT; i++) vars_q[i] <= '0;
            bv_req_q       <= 1'b0;
            bv_var_q       <= '0;
            bv_vals_q      <= '0;
            sel_valid_q    <= 1'b0;
            flip_req_q     <= 1'b0;
            flip_var_q     <= '0;
            rnd_q          <= 1'b0;
            done_q         <= 1'b0;
            flip_count_q   <= '0;
            random_count_q <= '0;
            sel_err_q      <= 1'b0;
        end else begin
            sel_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && !limit_o) begin
                        for (int unsigned i = 0; i < NSAT; i++)
                            vars_q[i] <= clause_vars_i[i*VAR_BITS +: VAR_BITS];
                        k_q      <= '0;
                        bv_req_q <= 1'b1;
                        bv_var_q <= clause_vars_i[VAR_BITS-1:0];
                        state_q  <= S_BV;
                    end
                end
                // bv_req_q is high for the whole of S_BV, so an ack here is a transfer
                S_BV: begin
                    if (bv_ack_i) begin
                        bv_vals_q[k_q*BVB +: BVB] <= bv_value_i;
                        if (k_q == NSAT_BITS'(NSAT - 1)) begin
                            bv_req_q    <= 1'b0;
                            sel_valid_q <= 1'b1;
                            sel_cnt_q   <= '0;
                            state_q     <= S_SEL;
                        end else begin
                            k_q      <= k_q + NSAT_BITS'(1);
                            bv_var_q <= vars_q[k_q + NSAT_BITS'(1)];
                        end
                    end
                end
                S_SEL: begin
                    if (sel_cnt_q == SCW'(SEL_LATENCY)) begin
                        rnd_q      <= random_sel_i;
                        flip_req_q <= 1'b1;
                        state_q    <= S_FLIP;
                        if (int'(select_i) >= NSAT) begin
                            flip_var_q <= vars_q[0];
                            sel_err_q  <= 1'b1;
                        end else begin
                            flip_var_q <= vars_q[select_i];
                        end
                    end else begin
                        sel_cnt_q <= sel_cnt_q + SCW'(1);
                    end
                end
                S_FLIP: begin
                    if (flip_ack_i) begin
                        flip_req_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                        if (flip_count_q != 32'(MAX_FLIPS))
                            flip_count_q <= flip_count_q + 32'd1;
                        if (rnd_q && (random_count_q != '1))
                            random_count_q <= random_count_q + 32'd1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flip_scheduler.sv
// Randomised scoreboard bench for flip_scheduler: stimulus pushes expected step results,
// a monitor pops and compares them on every done_o; a second instance checks the flip budget.
module tb_flip_scheduler;
    localparam int NSAT = 3;
    localparam int VB   = 10;
    localparam int BVB  = 5;
    localparam int SL   = 1;
    localparam int MAXF = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                 reset;
    logic                 start_i;
    logic [NSAT*VB-1:0]   clause_vars_i;
    logic                 busy_o, bv_req_o, bv_ack_i, sel_valid_o, random_sel_i;
    logic [VB-1:0]        bv_var_o, flip_var_o;
    logic [BVB-1:0]       bv_value_i;
    logic [NSAT*BVB-1:0]  break_values_o;
    logic [1:0]           select_i;
    logic                 flip_req_o, flip_ack_i, done_o, limit_o, sel_err_o;
    logic [31:0]          flip_count_o, random_count_o;

    logic                 start_s, s_busy, s_bv_req, s_sel_valid, s_flip_req, s_done, s_limit, s_sel_err;
    logic [VB-1:0]        s_bv_var, s_flip_var;
    logic [NSAT*BVB-1:0]  s_break_values;
    logic [31:0]          s_flip_count, s_random_count;
    logic                 s_bv_ack, s_flip_ack;

    flip_scheduler #(
        .NSAT(NSAT), .NSAT_BITS(2), .MAX_CLAUSES_PER_VARIABLE_BITS(BVB),
        .VAR_BITS(VB), .SEL_LATENCY(SL), .MAX_FLIPS(MAXF)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .clause_vars_i(clause_vars_i),
        .busy_o(busy_o), .bv_req_o(bv_req_o), .bv_var_o(bv_var_o), .bv_ack_i(bv_ack_i),
        .bv_value_i(bv_value_i), .break_values_o(break_values_o), .sel_valid_o(sel_valid_o),
        .select_i(select_i), .random_sel_i(random_sel_i), .flip_req_o(flip_req_o),
        .flip_var_o(flip_var_o), .flip_ack_i(flip_ack_i), .done_o(done_o),
        .flip_count_o(flip_count_o), .random_count_o(random_count_o), .limit_o(limit_o),
        .sel_err_o(sel_err_o)
    );

    flip_scheduler #(
        .NSAT(NSAT), .NSAT_BITS(2), .MAX_CLAUSES_PER_VARIABLE_BITS(BVB),
        .VAR_BITS(VB), .SEL_LATENCY(SL), .MAX_FLIPS(2)
    ) u_lim (
        .clk(clk), .reset(reset), .start_i(start_s), .clause_vars_i(clause_vars_i),
        .busy_o(s_busy), .bv_req_o(s_bv_req), .bv_var_o(s_bv_var), .bv_ack_i(s_bv_ack),
        .bv_value_i(bv_value_i), .break_values_o(s_break_values), .sel_valid_o(s_sel_valid),
        .select_i(select_i), .random_sel_i(random_sel_i), .flip_req_o(s_flip_req),
        .flip_var_o(s_flip_var), .flip_ack_i(s_flip_ack), .done_o(s_done),
        .flip_count_o(s_flip_count), .random_count_o(s_random_count), .limit_o(s_limit),
        .sel_err_o(s_sel_err)
    );

    assign s_bv_ack   = s_bv_req;
    assign s_flip_ack = s_flip_req;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference data: break value of every variable, plus expected step results
    logic [BVB-1:0] bvtab [1024];

    typedef struct {
        logic [NSAT*VB-1:0]  vars;
        logic [NSAT*BVB-1:0] bv;
        logic [VB-1:0]       fvar;
        int                  fcount;
        int                  rcount;
        bit                  serr;
        int                  start_cyc;
        int                  sel_ofs;
        int                  lat;
    } exp_t;

    exp_t sbq[$];
    int   m_fcount = 0;
    int   m_rcount = 0;
    bit   m_serr   = 0;

    int            bv_delay   = 0;
    int            flip_delay = 0;
    bit            stray_ack  = 0;
    logic [VB-1:0] seen[$];

    // break-value responder: acks after bv_delay wait cycles, answers from the table
    int            bv_wait = 0;
    logic [VB-1:0] held_var;
    always @(negedge clk) begin
        if (bv_req_o) begin
            if (bv_wait > 0) check("bv_var_stable", bv_var_o, held_var);
            if (bv_wait >= bv_delay) begin
                bv_ack_i   = 1'b1;
                bv_value_i = bvtab[bv_var_o];
                seen.push_back(bv_var_o);
                bv_wait    = 0;
            end else begin
                bv_ack_i   = 1'b0;
                bv_value_i = BVB'($urandom);
                held_var   = bv_var_o;
                bv_wait++;
            end
        end else begin
            bv_ack_i   = stray_ack;
            bv_value_i = BVB'($urandom);
            bv_wait    = 0;
        end
    end

    int fwait = 0;
    always @(negedge clk) begin
        if (flip_req_o) begin
            if (fwait >= flip_delay) begin
                flip_ack_i = 1'b1;
                fwait      = 0;
            end else begin
                flip_ack_i = 1'b0;
                fwait++;
            end
        end else begin
            flip_ack_i = 1'b0;
            fwait      = 0;
        end
    end

    // monitor: capture step observations, compare against the scoreboard on done_o
    logic [NSAT*BVB-1:0] cap_bv;
    logic [VB-1:0]       cap_fvar;
    int                  sel_pulses = 0;
    int                  sel_cyc    = 0;
    bit                  fcap       = 0;
    exp_t                me;
    always @(negedge clk) begin
        if (!busy_o) begin
            sel_pulses = 0;
            fcap       = 0;
            seen.delete();
        end
        if (sel_valid_o) begin
            sel_pulses++;
            cap_bv  = break_values_o;
            sel_cyc = cyc;
        end
        if (flip_req_o) begin
            if (fcap) check("flip_var_held", flip_var_o, cap_fvar);
            else begin
                cap_fvar = flip_var_o;
                fcap     = 1;
            end
        end
        if (done_o) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", done_o, 1'b0);
            end else begin
                me = sbq.pop_front();
                check("latency", cyc - me.start_cyc, me.lat);
                check("sel_valid_cycle", sel_cyc - me.start_cyc, me.sel_ofs);
                check("sel_valid_pulses", sel_pulses, 1);
                check("break_values_at_sel", cap_bv, me.bv);
                check("break_values_hold", break_values_o, me.bv);
                check("bv_request_count", seen.size(), NSAT);
                if (seen.size() == NSAT)
                    for (int i = 0; i < NSAT; i++)
                        check("bv_var_order", seen[i], me.vars[i*VB +: VB]);
                check("flip_var", cap_fvar, me.fvar);
                check("flip_count", flip_count_o, me.fcount);
                check("random_count", random_count_o, me.rcount);
                check("sel_err", sel_err_o, me.serr);
                check("limit", limit_o, me.fcount == MAXF);
            end
            seen.delete();
        end
    end

    task automatic run_step(input logic [NSAT*VB-1:0] cv, input logic [1:0] sel, input bit rnd,
                            input int bvd, input int fd, input bit noise);
        exp_t e;
        int   n;
        @(negedge clk);
        bv_delay      = bvd;
        flip_delay    = fd;
        clause_vars_i = cv;
        select_i      = sel;
        random_sel_i  = rnd;
        start_i       = 1'b1;
        m_fcount      = (m_fcount < MAXF) ? m_fcount + 1 : MAXF;
        if (rnd) m_rcount++;
        if (sel >= NSAT) m_serr = 1;
        e.vars      = cv;
        e.bv        = {bvtab[cv[29:20]], bvtab[cv[19:10]], bvtab[cv[9:0]]};
        e.fvar      = (sel < NSAT) ? cv[sel*VB +: VB] : cv[VB-1:0];
        e.fcount    = m_fcount;
        e.rcount    = m_rcount;
        e.serr      = m_serr;
        e.start_cyc = cyc;
        e.sel_ofs   = 1 + NSAT * (bvd + 1);
        e.lat       = e.sel_ofs + SL + 1 + fd + 1;
        sbq.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
        n = 0;
        while (!done_o && n < 300) begin
            if (noise && (bv_req_o || flip_req_o)) begin
                start_i       = 1'b1;
                clause_vars_i = 30'($urandom);
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start_i = 1'b0;
        if (!done_o) check("step_done_seen", done_o, 1'b1);
    endtask

    task automatic lim_step();
        int n;
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        n = 0;
        while (!s_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("lim_done_seen", s_done, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start_i = 1'b0; start_s = 1'b0; clause_vars_i = '0;
        select_i = '0; random_sel_i = 1'b0;
        bv_ack_i = 1'b0; bv_value_i = '0; flip_ack_i = 1'b0;
        for (int i = 0; i < 1024; i++) bvtab[i] = BVB'($urandom);
        bvtab[5] = 5'd4; bvtab[9] = 5'd2; bvtab[12] = 5'd7;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {busy_o, bv_req_o, bv_var_o, sel_valid_o, flip_req_o, flip_var_o,
                             done_o, limit_o, sel_err_o, break_values_o}, '0);
        check("reset_counts", {flip_count_o, random_count_o}, '0);
        reset = 1'b0;

        // flip budget on the MAX_FLIPS=2 instance
        lim_step();
        check("lim_count1", s_flip_count, 1);
        check("lim_limit1", s_limit, 1'b0);
        lim_step();
        @(negedge clk);
        check("lim_count2", s_flip_count, 2);
        check("lim_limit2", s_limit, 1'b1);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("lim_start_ignored_busy", s_busy, 1'b0);
        end
        check("lim_count_hold", s_flip_count, 2);

        // directed steps: clause {5,9,12}
        run_step({10'd12, 10'd9, 10'd5}, 2'd1, 1'b0, 0, 0, 1'b0);
        run_step({10'd12, 10'd9, 10'd5}, 2'd2, 1'b1, 3, 0, 1'b0);
        run_step({10'd77, 10'd300, 10'd41}, 2'd0, 1'b1, 1, 2, 1'b1);

        // stray acks in IDLE must not start anything
        @(negedge clk);
        stray_ack = 1;
        repeat (4) begin
            @(negedge clk);
            check("stray_ack_busy", busy_o, 1'b0);
        end
        stray_ack = 0;
        check("stray_ack_count", flip_count_o, m_fcount);

        // out-of-range selection falls back to slot 0 and latches the error
        run_step({10'd100, 10'd200, 10'd300}, 2'd3, 1'b0, 0, 1, 1'b0);
        run_step({10'd1, 10'd2, 10'd3}, 2'd1, 1'b0, 0, 0, 1'b0);

        for (int s = 0; s < 30; s++)
            run_step({10'($urandom), 10'($urandom), 10'($urandom)}, 2'($urandom),
                     1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)));

        // reset while a flip is outstanding aborts the step
        @(negedge clk);
        flip_delay    = 100000;
        bv_delay      = 0;
        clause_vars_i = {10'd8, 10'd7, 10'd6};
        select_i      = 2'd2;
        start_i       = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int n = 0; n < 30 && !flip_req_o; n++) @(negedge clk);
        check("abort_in_flip", flip_req_o, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ctrl", {busy_o, bv_req_o, bv_var_o, sel_valid_o, flip_req_o, flip_var_o,
                             done_o, limit_o, sel_err_o, break_values_o}, '0);
        check("abort_counts", {flip_count_o, random_count_o}, '0);
        m_fcount = 0; m_rcount = 0; m_serr = 0;
        flip_delay = 0;
        repeat (10) begin
            @(negedge clk);
            check("abort_no_done", done_o, 1'b0);
        end
        run_step({10'd8, 10'd7, 10'd6}, 2'd2, 1'b1, 0, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
